mem_access_unit: RTL and testbench

- MEM-stage load/store engine, successor to the ID-stage memory-control decode.
- Takes the decoded memory-control bundle (read/write flag, sign-extend flag, access size, address, store data). Performs alignment checking, byte-lane steering, sign/zero extension and a ready-based handshake to the data RAM.
- Stalls the pipeline until each access completes. Parametrised in data width, with a bus-timeout watchdog.

---
 rtl/mem_pkg.sv | 13 +
 rtl/mem_lane_align.sv | 40 ++++
 rtl/mem_access_unit.sv | 145 ++++++++++++++
 tb/tb_mem_access_unit.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: access-size and FSM state encodings shared by the load/store unit
package mem_pkg;
  localparam logic [1:0] MEM_SIZE_BYTE  = 2'd0;
  localparam logic [1:0] MEM_SIZE_HALF  = 2'd1;
  localparam logic [1:0] MEM_SIZE_WORD  = 2'd2;
  localparam logic [1:0] MEM_SIZE_DWORD = 2'd3;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUS  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;
  function automatic int strb_width(input int dw);
    return dw / 8;
  endfunction
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: store lane steering/strobes and load extraction/extension
module mem_lane_align
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = strb_width(DATA_WIDTH),
  parameter int OFF_W = $clog2(STRB_WIDTH)
) (
  input  logic [OFF_W-1:0]      i_st_off,
  input  logic [1:0]            i_st_size,
  input  logic [DATA_WIDTH-1:0] i_st_data,
  output logic [DATA_WIDTH-1:0] o_st_data,
  output logic [STRB_WIDTH-1:0] o_st_strb,
  input  logic [OFF_W-1:0]      i_ld_off,
  input  logic [1:0]            i_ld_size,
  input  logic                  i_ld_sign,
  input  logic [DATA_WIDTH-1:0] i_ld_raw,
  output logic [DATA_WIDTH-1:0] o_ld_data
);
  logic [7:0]            w_size_mask;
  logic [6:0]            w_ld_bits;
  logic [DATA_WIDTH-1:0] w_shift;
  logic [DATA_WIDTH-1:0] w_keep;
  logic [DATA_WIDTH-1:0] w_top;
  logic                  w_neg;
  always_comb begin
    w_size_mask = (i_st_size == MEM_SIZE_BYTE) ? 8'h01 :
                  (i_st_size == MEM_SIZE_HALF) ? 8'h03 :
                  (i_st_size == MEM_SIZE_WORD) ? 8'h0F : 8'hFF;
    o_st_strb   = STRB_WIDTH'(w_size_mask << i_st_off);
    o_st_data   = i_st_data << {i_st_off, 3'b000};
    w_ld_bits   = 7'd8 << i_ld_size;
    w_shift     = i_ld_raw >> {i_ld_off, 3'b000};
    // a shift by the full width yields zero, so a full-width access keeps every bit
    w_keep      = ~({DATA_WIDTH{1'b1}} << w_ld_bits);
    w_top       = w_keep & ~(w_keep >> 1);
    w_neg       = i_ld_sign & |(w_shift & w_top);
    o_ld_data   = (w_shift & w_keep) | (w_neg ? ~w_keep : '0);
  end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store engine with alignment checks, RAM handshake and timeout
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int STRB_WIDTH = strb_width(DATA_WIDTH),
  parameter int TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_read_flag,
  input  logic                  mem_write_flag,
  input  logic                  mem_sign_ext_flag,
  input  logic [1:0]            mem_size,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_write_data,
  input  logic                  mem_flush,
  output logic                  ram_en,
  output logic [STRB_WIDTH-1:0] ram_write_en,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_write_data,
  input  logic [DATA_WIDTH-1:0] ram_read_data,
  input  logic                  ram_ready,
  output logic                  stall_request,
  output logic [DATA_WIDTH-1:0] load_data,
  output logic                  result_valid,
  output logic                  addr_err_load,
  output logic                  addr_err_store,
  output logic                  bus_err
);
  localparam int OFF_W = $clog2(STRB_WIDTH);
  logic [1:0]            r_state;
  logic [7:0]            r_cnt;
  logic                  r_flush;
  logic                  r_write;
  logic                  r_sign;
  logic [1:0]            r_size;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [STRB_WIDTH-1:0] r_strb;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_load;
  logic                  r_berr;
  logic                  r_ael;
  logic                  r_aes;
  logic                  w_req;
  logic [2:0]            w_off_mask;
  logic                  w_illegal;
  logic                  w_go;
  logic                  w_bus;
  logic                  w_resp;
  logic [DATA_WIDTH-1:0] w_st_data;
  logic [STRB_WIDTH-1:0] w_st_strb;
  logic [DATA_WIDTH-1:0] w_ld_data;
  assign w_req      = (mem_read_flag | mem_write_flag) & ~mem_flush;
  assign w_off_mask = (3'd1 << mem_size) - 3'd1;
  assign w_illegal  = (|(mem_addr[2:0] & w_off_mask)) | (mem_size == MEM_SIZE_DWORD && DATA_WIDTH < 64);
  assign w_go       = (r_state == ST_IDLE) & w_req & ~w_illegal;
  assign w_bus      = r_state == ST_BUS;
  assign w_resp     = (r_state == ST_RESP) & ~r_flush;
  mem_lane_align #(
    .DATA_WIDTH(DATA_WIDTH),
    .STRB_WIDTH(STRB_WIDTH),
    .OFF_W(OFF_W)
  ) u_align (
    .i_st_off (mem_addr[OFF_W-1:0]),
    .i_st_size(mem_size),
    .i_st_data(mem_write_data),
    .o_st_data(w_st_data),
    .o_st_strb(w_st_strb),
    .i_ld_off (r_addr[OFF_W-1:0]),
    .i_ld_size(r_size),
    .i_ld_sign(r_sign),
    .i_ld_raw (ram_read_data),
    .o_ld_data(w_ld_data)
  );
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_flush <= 1'b0;
      r_write <= 1'b0;
      r_sign  <= 1'b0;
      r_size  <= '0;
      r_addr  <= '0;
      r_strb  <= '0;
      r_wdata <= '0;
      r_load  <= '0;
      r_berr  <= 1'b0;
      r_ael   <= 1'b0;
      r_aes   <= 1'b0;
    end else begin
      r_ael <= 1'b0;
      r_aes <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_flush <= 1'b0;
          if (w_go) begin
            r_state <= ST_BUS;
            r_cnt   <= '0;
            r_addr  <= mem_addr;
            r_size  <= mem_size;
            r_sign  <= mem_sign_ext_flag;
            r_write <= mem_write_flag;
            r_wdata <= mem_write_flag ? w_st_data : '0;
            r_strb  <= mem_write_flag ? w_st_strb : '0;
          end else if (w_req) begin
            r_ael <= ~mem_write_flag;
            r_aes <= mem_write_flag;
          end
        end
        ST_BUS: begin
          // a flushed access still finishes on the bus; only its result is dropped
          r_flush <= r_flush | mem_flush;
          r_cnt   <= r_cnt + 8'd1;
          if (ram_ready) begin
            r_state <= ST_RESP;
            r_load  <= r_write ? '0 : w_ld_data;
            r_berr  <= 1'b0;
          end else if (r_cnt == 8'(TIMEOUT - 1)) begin
            r_state <= ST_RESP;
            r_load  <= '0;
            r_berr  <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_flush <= 1'b0;
          r_berr  <= 1'b0;
          r_load  <= '0;
        end
      endcase
    end
  end
  assign ram_en         = w_bus;
  assign ram_write_en   = w_bus ? r_strb : '0;
  assign ram_addr       = w_bus ? {r_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}} : '0;
  assign ram_write_data = w_bus ? r_wdata : '0;
  assign stall_request  = w_bus | w_go;
  assign result_valid   = w_resp;
  assign load_data      = w_resp ? r_load : '0;
  assign bus_err        = w_resp & r_berr;
  assign addr_err_load  = r_ael;
  assign addr_err_store = r_aes;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: 32- and 64-bit instances checked every cycle against a transaction-level model
module tb_mem_access_unit;
  localparam int TMO = 15;
  typedef struct packed {
    logic        en;
    logic [7:0]  we;
    logic [31:0] addr;
    logic [63:0] wd;
    logic        stall;
    logic [63:0] ld;
    logic        rv;
    logic        ael;
    logic        aes;
    logic        berr;
  } obs_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic sel = 1'b0, rd = 1'b0, wr = 1'b0, sg = 1'b0, fl = 1'b0, rdy = 1'b0;
  logic [1:0] sz = '0;
  logic [31:0] ad = '0;
  logic [63:0] wdv = '0, rdv = '0;
  logic en32, stall32, rv32, ael32, aes32, be32;
  logic [3:0] we32;
  logic [31:0] ra32, wd32, ld32;
  logic en64, stall64, rv64, ael64, aes64, be64;
  logic [7:0] we64;
  logic [31:0] ra64;
  logic [63:0] wd64, ld64;
  int errors = 0, checks = 0, cyc = 0;
  bit chk_on = 1'b0;
  obs_t q0[$], q1[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  mem_access_unit #(.DATA_WIDTH(32), .TIMEOUT(TMO)) dut32 (
    .clk(clk), .rst(rst), .mem_read_flag(rd & ~sel), .mem_write_flag(wr & ~sel),
    .mem_sign_ext_flag(sg), .mem_size(sz), .mem_addr(ad), .mem_write_data(wdv[31:0]),
    .mem_flush(fl), .ram_en(en32), .ram_write_en(we32), .ram_addr(ra32),
    .ram_write_data(wd32), .ram_read_data(rdv[31:0]), .ram_ready(rdy & ~sel),
    .stall_request(stall32), .load_data(ld32), .result_valid(rv32),
    .addr_err_load(ael32), .addr_err_store(aes32), .bus_err(be32)
  );
  mem_access_unit #(.DATA_WIDTH(64), .TIMEOUT(TMO)) dut64 (
    .clk(clk), .rst(rst), .mem_read_flag(rd & sel), .mem_write_flag(wr & sel),
    .mem_sign_ext_flag(sg), .mem_size(sz), .mem_addr(ad), .mem_write_data(wdv),
    .mem_flush(fl), .ram_en(en64), .ram_write_en(we64), .ram_addr(ra64),
    .ram_write_data(wd64), .ram_read_data(rdv), .ram_ready(rdy & sel),
    .stall_request(stall64), .load_data(ld64), .result_valid(rv64),
    .addr_err_load(ael64), .addr_err_store(aes64), .bus_err(be64)
  );
  function automatic bit m_legal(int dw, logic [1:0] z, logic [31:0] a);
    return (a % (32'd1 << z)) == 0 && !(z == 2'd3 && dw == 32);
  endfunction
  function automatic logic [7:0] m_strb(int dw, logic [1:0] z, logic [31:0] a);
    int off;
    logic [7:0] s;
    off = int'(a % (dw / 8));
    s = '0;
    for (int i = 0; i < (1 << z); i++) if (off + i < dw / 8) s[off + i] = 1'b1;
    return s;
  endfunction
  function automatic logic [63:0] m_steer(int dw, logic [31:0] a, logic [63:0] wv);
    int off;
    logic [127:0] t;
    off = int'(a % (dw / 8));
    t = {64'b0, (dw == 32) ? {32'b0, wv[31:0]} : wv} << (8 * off);
    return (dw == 32) ? {32'b0, t[31:0]} : t[63:0];
  endfunction
  function automatic logic [63:0] m_load(int dw, logic [1:0] z, bit s, logic [31:0] a, logic [63:0] rv);
    int off, nb;
    logic [63:0] res;
    off = int'(a % (dw / 8));
    nb = 1 << z;
    res = '0;
    for (int i = 0; i < nb; i++) res[8*i +: 8] = rv[8*(off+i) +: 8];
    if (s && res[8*nb-1]) for (int i = nb; i < dw / 8; i++) res[8*i +: 8] = 8'hFF;
    return res;
  endfunction
  task automatic chk(string nm, logic [63:0] g, logic [63:0] e);
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, g, e);
    end
  endtask
  task automatic cmp(int w, obs_t g, obs_t e);
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL dut%0d cycle %0d got=%h exp=%h", w, cyc, g, e);
    end
  endtask
  always @(negedge clk) begin
    obs_t e0, e1, g0, g1;
    if (chk_on) begin
      e0 = (q0.size() > 0) ? q0.pop_front() : '0;
      e1 = (q1.size() > 0) ? q1.pop_front() : '0;
      g0 = {en32, 4'b0, we32, ra32, 32'b0, wd32, stall32, 32'b0, ld32, rv32, ael32, aes32, be32};
      g1 = {en64, we64, ra64, wd64, stall64, ld64, rv64, ael64, aes64, be64};
      cmp(32, g0, e0);
      cmp(64, g1, e1);
    end
  end
  // drive one instruction, holding it while the pipeline is stalled, and queue the expected outputs
  task automatic run(bit k, bit w, bit r, bit s, logic [1:0] z, logic [31:0] a, logic [63:0] wv,
                     logic [63:0] rv, int dly, int fl_at, int rs_at);
    int dw, n, last;
    bit to, req, ok, flushed, live, pres;
    obs_t e;
    dw = k ? 64 : 32;
    to = !(dly >= 1 && dly <= TMO);
    n = to ? TMO : dly;
    req = (w | r) && fl_at != 0;
    ok = req && m_legal(dw, z, a);
    last = ok ? (rs_at > 0 ? rs_at + 1 : n + 1) : 1;
    flushed = fl_at >= 1 && fl_at <= n;
    sel = k; sz = z; ad = a; sg = s; wdv = wv; rdv = rv;
    for (int c = 0; c <= last; c++) begin
      live = ok && !(rs_at > 0 && c > rs_at);
      pres = ok ? (live && c <= n + 1) : (c == 0);
      rd = pres & r;
      wr = pres & w;
      fl = (c == fl_at);
      rdy = live && !to && c == dly;
      rst = !(rs_at > 0 && c == rs_at);
      e = '0;
      if (req && !ok && c == 1) begin
        e.aes = w;
        e.ael = !w;
      end
      if (live) begin
        if (c == 0) e.stall = 1'b1;
        else if (c <= n) begin
          e.en = 1'b1;
          e.stall = 1'b1;
          e.addr = a - a % (dw / 8);
          e.we = w ? m_strb(dw, z, a) : 8'h00;
          e.wd = w ? m_steer(dw, a, wv) : 64'h0;
        end else if (!flushed) begin
          e.rv = 1'b1;
          e.berr = to;
          e.ld = (w || to) ? 64'h0 : m_load(dw, z, s, a, rv);
        end
      end
      if (k) q1.push_back(e);
      else q0.push_back(e);
      @(posedge clk);
      #1;
    end
    rd = 1'b0; wr = 1'b0; fl = 1'b0; rdy = 1'b0; rst = 1'b1;
  endtask
  task automatic rand_txn();
    bit k, w, r;
    logic [1:0] z;
    logic [31:0] a;
    int dly, fl_at, n, p;
    k = 1'($urandom_range(0, 1));
    z = 2'($urandom_range(0, 3));
    p = $urandom_range(0, 2);
    w = p != 1;
    r = p != 0;
    a = $urandom;
    if ($urandom_range(0, 4) != 0) a = a & ~((32'd1 << z) - 32'd1);
    p = $urandom_range(0, 19);
    dly = p < 12 ? 1 + p % 4 : p < 15 ? TMO : p < 17 ? 0 : $urandom_range(5, 14);
    n = (dly >= 1 && dly <= TMO) ? dly : TMO;
    p = $urandom_range(0, 9);
    fl_at = p == 0 ? 0 : p == 1 ? $urandom_range(1, n) : -1;
    run(k, w, r, 1'($urandom_range(0, 1)), z, a, {$urandom, $urandom}, {$urandom, $urandom}, dly, fl_at, -1);
    if ($urandom_range(0, 3) == 0) begin
      @(posedge clk);
      #1;
    end
  endtask
  initial begin
    @(posedge clk);
    #1;
    chk_on = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    chk("pin_lh", m_load(32, 2'd1, 1'b1, 32'h2002, 64'h80011234), 64'h00000000FFFF8001);
    chk("pin_lhu", m_load(32, 2'd1, 1'b0, 32'h2002, 64'h80011234), 64'h0000000000008001);
    chk("pin_sb_data", m_steer(32, 32'h1003, 64'hAB), 64'h00000000AB000000);
    chk("pin_sb_strb", {56'b0, m_strb(32, 2'd0, 32'h1003)}, 64'h8);
    chk("pin_sd_strb", {56'b0, m_strb(64, 2'd3, 32'h4008)}, 64'hFF);
    chk("pin_lw64", m_load(64, 2'd2, 1'b1, 32'h4004, 64'h89ABCDEF01234567), 64'hFFFFFFFF89ABCDEF);
    chk("pin_lw_odd", {63'b0, m_legal(32, 2'd2, 32'h3001)}, 64'h0);
    run(0, 1, 0, 0, 2'd0, 32'h1003, 64'hAB, 64'h5555AAAA, 1, -1, -1);
    run(0, 0, 1, 1, 2'd1, 32'h2002, 64'h0, 64'h80015A5A, 2, -1, -1);
    run(0, 0, 1, 0, 2'd1, 32'h2002, 64'h0, 64'h80015A5A, 1, -1, -1);
    run(0, 0, 1, 1, 2'd2, 32'h3001, 64'h0, 64'h12345678, 1, -1, -1);
    run(0, 1, 0, 0, 2'd1, 32'h3001, 64'h1234, 64'h0, 1, -1, -1);
    run(1, 1, 0, 0, 2'd3, 32'h4008, 64'h0123456789ABCDEF, 64'h0, 5, -1, -1);
    run(1, 0, 1, 1, 2'd2, 32'h4004, 64'h0, 64'h89ABCDEF01234567, 1, -1, -1);
    run(0, 0, 1, 0, 2'd2, 32'h5000, 64'h0, 64'hCAFEF00D, 0, -1, -1);
    run(0, 0, 1, 0, 2'd2, 32'h5004, 64'h0, 64'hCAFEF00D, TMO, -1, -1);
    run(0, 0, 1, 1, 2'd2, 32'h6000, 64'h0, 64'h87654321, 3, 2, -1);
    run(0, 0, 1, 1, 2'd2, 32'h7000, 64'h0, 64'h87654321, 5, -1, 2);
    run(0, 1, 0, 0, 2'd3, 32'h8000, 64'h11, 64'h0, 1, -1, -1);
    run(1, 1, 1, 0, 2'd2, 32'h9004, 64'hDEADBEEF, 64'h0123456789ABCDEF, 2, -1, -1);
    run(0, 0, 1, 0, 2'd0, 32'hA001, 64'h0, 64'h0000FF00, 1, 0, -1);
    run(1, 0, 1, 1, 2'd0, 32'hB007, 64'h0, 64'h80FFFFFFFFFFFFFF, 1, -1, -1);
    for (int i = 0; i < 300; i++) rand_txn();
    repeat (3) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
